iter_shift_right: RTL and testbench
===================================

Name: iter_shift_right

Overview:
- Multi-cycle right shifter for the LEGv8 datapath's LSR/ASR instructions.
- Complements the combinational left-shift-by-2 used for branch offsets; this block moves data in the other direction.
- Shifts one bit position per clock under a Start/Busy/Done handshake.
- Sits beside the ALU; the control unit stalls on Busy.

Parameters:
- WIDTH, 64, data width in bits.
- SHAMT_W, 6, shift-amount width; must satisfy 2**SHAMT_W >= WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  synchronous active-low reset, sampled on rising CLK.
- Start  input  1  request; sampled only when not Busy.
- In  input  WIDTH  operand, captured when Start is accepted.
- Shamt  input  SHAMT_W  unsigned shift amount, captured with In.
- Arith  input  1  0 = logical (zero fill), 1 = arithmetic (sign fill from In[WIDTH-1]).
- Busy  output  1  high while a shift is in progress.
- Done  output  1  one-cycle pulse when Out holds a new result.
- Out  output  WIDTH  result register, held until the next accepted Start.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - state = IDLE; Out = 0, Busy = 0, Done = 0, internal counter = 0.
  - Takes priority over everything, including mid-operation; any partial result is discarded.
- States: IDLE, SHIFT, FIN.
- IDLE:
  - Start=1 loads In into Out and Shamt into the counter, and latches Arith.
  - Next state is SHIFT if Shamt != 0, else FIN.
  - Busy rises in the cycle after acceptance.
- SHIFT: each cycle Out = {fill, Out[WIDTH-1:1]} and counter decrements. Fill is:
  - Out[WIDTH-1] when Arith is latched high, so sign propagates;
  - 0 otherwise.
- SHIFT exit: the cycle the counter reaches 0, next state is FIN.
- FIN:
  - Done=1 and Busy=0 for exactly one cycle; Out is final.
  - Start=1 in FIN is accepted exactly as in IDLE (back-to-back ops); otherwise go to IDLE.
- Latency: Done asserts Shamt+1 cycles after the accepting edge. Shamt=0 gives Done 1 cycle later with Out=In.
- Busy=1 exactly in SHIFT. Start while Busy is ignored, and In/Shamt/Arith changes during SHIFT have no effect.
- Shamt >= WIDTH is not reachable when WIDTH=64 and SHAMT_W=6. For other parameterisations the counter runs the full Shamt; the result saturates to all-fill bits.
- Out is stable in IDLE and FIN; it changes only on load or shift edges.

Optional Feature:
- Macro: ITER_SHIFT_LSL_EN.
- When defined:
  - Adds port Dir input 1 (0 = right, 1 = left), latched at Start alongside Arith.
  - With Dir=1, each SHIFT cycle performs Out = {Out[WIDTH-2:0], 1'b0} and Arith is ignored.
  - Handshake and latency are identical to right shifts.
- When undefined: the Dir port does not exist and only LSR/ASR are supported.

Decomposition:
- Package shift_pkg holds:
  - state encoding: IDLE=2'd0, SHIFT=2'd1, FIN=2'd2;
  - constants SHIFT_LSR=1'b0 and SHIFT_ASR=1'b1;
  - the Dir encodings.
- Sub-module shift_step: combinational single-position shifter taking (value, arith, dir) and producing the next value. It is instantiated once inside iter_shift_right.

Test Plan:
- In=16, Shamt=2, Arith=0, Start pulse → Busy high for 2 cycles, Done at cycle 3, Out=4.
- In=64'h8000_0000_0000_0000, Shamt=4:
  - Arith=1 → Out=64'hF800_0000_0000_0000;
  - repeated with Arith=0 → Out=64'h0800_0000_0000_0000.
- In=8, Shamt=0 → Done the next cycle, Busy never high, Out=8.
- In=64'hFFFF_FFFF_FFFF_FFFF, Shamt=63:
  - Arith=0 → Out=1 with Done at cycle 64;
  - Arith=1 → Out=all ones.
- Start In=2, Shamt=5, then assert Start with In=9 at cycle 2 → second Start ignored, Out=0. Then RST_N low during a new Shamt=10 op → next edge Out=0, Busy=0, Done=0. A following op with In=4, Shamt=1 gives Out=2.
- With ITER_SHIFT_LSL_EN defined: In=2, Shamt=2, Dir=1 → Out=8 at cycle 3. Back-to-back Start in FIN with In=32, Shamt=3, Dir=0 → Out=4.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared state encoding and shift-mode constants for iter_shift_right
package shift_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FIN = 2'd2} state_t;
  localparam logic SHIFT_LSR = 1'b0;
  localparam logic SHIFT_ASR = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational one-position shifter (right logical/arithmetic or left)
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             arith_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] next_o
);
  assign next_o = dir_i == DIR_LEFT ? {val_i[WIDTH-2:0], 1'b0}
                                    : {arith_i == SHIFT_ASR & val_i[WIDTH-1], val_i[WIDTH-1:1]};
endmodule

// File: rtl/iter_shift_right.sv
// iter_shift_right: one-bit-per-clock LSR/ASR shifter with Start/Busy/Done; ITER_SHIFT_LSL_EN adds Dir for LSL
module iter_shift_right
  import shift_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               Start,
  input  logic [WIDTH-1:0]   In,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Arith,
`ifdef ITER_SHIFT_LSL_EN
  input  logic               Dir,
`endif
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Out
);
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d, step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               arith_q, arith_d, dir_q, dir_d, dir_in;
`ifdef ITER_SHIFT_LSL_EN
  assign dir_in = Dir;
`else
  assign dir_in = DIR_RIGHT;
`endif
  shift_step #(.WIDTH(WIDTH)) u_step (.val_i(out_q), .arith_i(arith_q), .dir_i(dir_q), .next_o(step));
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    arith_d = arith_q;
    dir_d   = dir_q;
    if (state_q == SHIFT) begin
      out_d   = step;
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == SHAMT_W'(1) ? FIN : SHIFT;
    end else if (Start) begin
      out_d   = In;
      cnt_d   = Shamt;
      arith_d = Arith;
      dir_d   = dir_in;
      state_d = Shamt != '0 ? SHIFT : FIN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      arith_q <= SHIFT_LSR;
      dir_q   <= DIR_RIGHT;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
      dir_q   <= dir_d;
    end
  end
  assign Busy = state_q == SHIFT;
  assign Done = state_q == FIN;
  assign Out  = out_q;
endmodule

// File: tb/tb_iter_shift_right.sv
// tb_iter_shift_right: directed + randomized checks of iter_shift_right against an arithmetic reference
module tb_iter_shift_right;
  logic        CLK = 1'b0, RST_N = 1'b0, Start = 1'b0, Arith = 1'b0;
  logic [63:0] In = '0;
  logic [5:0]  Shamt = '0;
`ifdef ITER_SHIFT_LSL_EN
  logic        Dir = 1'b0;
`endif
  logic        Busy, Done;
  logic [63:0] Out;
  logic [63:0] last_exp = '0;
  int          vectors = 0, errors = 0;

  iter_shift_right dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .In(In), .Shamt(Shamt), .Arith(Arith),
`ifdef ITER_SHIFT_LSL_EN
    .Dir(Dir),
`endif
    .Busy(Busy), .Done(Done), .Out(Out)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] v, input int sh, input bit ar, input bit d);
    if (d) return v << sh;
    if (ar) return 64'($signed(v) >>> sh);
    return v >> sh;
  endfunction

  // Accept on the next edge, scramble inputs while busy, and stop in the Done cycle.
  task automatic run_op(input logic [63:0] v, input int sh, input bit ar, input bit d);
    last_exp = model(v, sh, ar, d);
    Start = 1'b1; In = v; Shamt = 6'(sh); Arith = ar;
`ifdef ITER_SHIFT_LSL_EN
    Dir = d;
`endif
    tick;
    for (int k = 1; k <= sh; k++) begin
      Start = (k % 2 == 0) ? 1'b1 : 1'($urandom);
      In    = {$urandom, $urandom};
      Shamt = 6'($urandom);
      Arith = 1'($urandom);
`ifdef ITER_SHIFT_LSL_EN
      Dir   = 1'($urandom);
`endif
      check("busy_phase", {62'b0, Busy, Done}, 64'd2);
      if (k == 1) check("load", Out, v);
      tick;
    end
    Start = 1'b0;
    check("done_phase", {62'b0, Busy, Done}, 64'd1);
    check("result", Out, last_exp);
  endtask

  task automatic idle;
    Start = 1'b0;
    tick;
    check("idle_hs", {62'b0, Busy, Done}, 64'd0);
    check("idle_hold", Out, last_exp);
  endtask

  initial begin
    RST_N = 1'b0;
    tick;
    tick;
    check("rst_out", Out, 64'd0);
    check("rst_hs", {62'b0, Busy, Done}, 64'd0);
    RST_N = 1'b1;
    run_op(64'd16, 2, 1'b0, 1'b0); idle;
    check("lsr_16_2", last_exp, 64'd4);
    run_op(64'h8000_0000_0000_0000, 4, 1'b1, 1'b0); idle;
    run_op(64'h8000_0000_0000_0000, 4, 1'b0, 1'b0); idle;
    run_op(64'd8, 0, 1'b0, 1'b0); idle;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 63, 1'b0, 1'b0); idle;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 63, 1'b1, 1'b0); idle;
    run_op(64'd2, 5, 1'b0, 1'b0); idle;
    Start = 1'b1; In = {$urandom, $urandom}; Shamt = 6'd10; Arith = 1'b0;
    tick;
    Start = 1'b0;
    tick;
    tick;
    RST_N = 1'b0;
    tick;
    check("midrst_out", Out, 64'd0);
    check("midrst_hs", {62'b0, Busy, Done}, 64'd0);
    RST_N = 1'b1;
    tick;
    check("postrst_hs", {62'b0, Busy, Done}, 64'd0);
    check("postrst_out", Out, 64'd0);
    run_op(64'd4, 1, 1'b0, 1'b0); idle;
`ifdef ITER_SHIFT_LSL_EN
    run_op(64'd2, 2, 1'b0, 1'b1);
    run_op(64'd32, 3, 1'b0, 1'b0); idle;
`endif
    for (int i = 0; i < 25; i++) begin
      logic [63:0] v;
      int sh;
      bit ar, d;
      v  = {$urandom, $urandom};
      sh = ($urandom % 4 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 12));
      ar = 1'($urandom);
      d  = 1'b0;
`ifdef ITER_SHIFT_LSL_EN
      d  = 1'($urandom);
`endif
      run_op(v, sh, ar, d);
      if ($urandom % 2 == 0) idle;
    end
    idle;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
